// File: rtl/mux_scan_seq.sv
// ---------------------------------------------------------------------------
// mux_scan_seq
//
// Registered N-channel multiplexer with two modes:
//   manual : out follows the channel picked by sel, one cycle later
//   scan   : walks every channel in turn, holding each one for DWELL cycles
//            and pulsing frame_done when the walk wraps back to the start
//
// Optional feature (macro MUX_SCAN_SKIP_EN):
//   When defined, a skip_mask port is added. Channels whose mask bit is 1 are
//   never shown in scan mode. The mask is ignored in manual mode.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in         packed channels, channel k = in[k*WIDTH +: WIDTH]
//   sel        manual-mode channel select
//   en         block enable (0 forces IDLE)
//   mode       0 = manual, 1 = scan
//   skip_mask  per-channel scan skip (MUX_SCAN_SKIP_EN only)
//   out        registered selected data
//   out_sel    index of the channel currently on out
//   out_valid  out / out_sel valid this cycle
//   frame_done one-cycle pulse on the first cycle of a new scan frame
//   sel_err    manual select out of range (sel >= CHANNELS)
// ---------------------------------------------------------------------------
module mux_scan_seq #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      en,
    input  logic                      mode,
`ifdef MUX_SCAN_SKIP_EN
    input  logic [CHANNELS-1:0]       skip_mask,
`endif
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    output logic                      frame_done,
    output logic                      sel_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [WIDTH-1:0]  out_r;
    logic [SEL_W-1:0]  out_sel_r;
    logic              out_valid_r;
    logic              frame_done_r;
    logic              sel_err_r;
    logic [15:0]       dwell_r;

    logic [WIDTH-1:0]  out_nxt_s;
    logic [SEL_W-1:0]  out_sel_nxt_s;
    logic              out_valid_nxt_s;
    logic              frame_done_nxt_s;
    logic              sel_err_nxt_s;
    logic [15:0]       dwell_nxt_s;

    logic [CHANNELS-1:0] mask_s;
    logic              sel_ok_s;
    logic              scan_start_s;
    logic              first_found_s;
    logic [SEL_W-1:0]  first_idx_s;
    logic              hi_found_s;
    logic [SEL_W-1:0]  hi_idx_s;
    logic [SEL_W-1:0]  adv_idx_s;
    logic              adv_wrap_s;

`ifdef MUX_SCAN_SKIP_EN
    assign mask_s = skip_mask;
`else
    assign mask_s = '0;
`endif

    // Channel picker; an index outside 0..CHANNELS-1 yields zero.
    function automatic logic [WIDTH-1:0] chan_at(
        input logic [CHANNELS*WIDTH-1:0] bus,
        input logic [SEL_W-1:0]          idx
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(idx) == k) begin
                r = bus[k*WIDTH +: WIDTH];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // For power-of-two channel counts every select value is legal, so the
    // range compare is only built when some codes are unused.
    generate
        if (CHANNELS == (1 << SEL_W)) begin : g_sel_full
            assign sel_ok_s = 1'b1;
        end else begin : g_sel_part
            assign sel_ok_s = (sel <= SEL_W'(CHANNELS - 1));
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: en has priority over mode.
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (!en) begin
            state_nxt_s = ST_IDLE;
        end else if (mode) begin
            state_nxt_s = ST_SCAN;
        end else begin
            state_nxt_s = ST_MANUAL;
        end
    end

    // Scan-order search: lowest scannable channel, and next scannable
    // channel above the one currently shown (wrapping to the lowest).
    always_comb begin
        first_found_s = 1'b0;
        first_idx_s   = '0;
        hi_found_s    = 1'b0;
        hi_idx_s      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!first_found_s && !mask_s[k]) begin
                first_found_s = 1'b1;
                first_idx_s   = SEL_W'(k);
            end else begin
                first_found_s = first_found_s;
            end
            if (!hi_found_s && !mask_s[k] && (k > int'(out_sel_r))) begin
                hi_found_s = 1'b1;
                hi_idx_s   = SEL_W'(k);
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        if (hi_found_s) begin
            adv_idx_s  = hi_idx_s;
            adv_wrap_s = 1'b0;
        end else begin
            adv_idx_s  = first_idx_s;
            adv_wrap_s = 1'b1;
        end
    end

    // A scan restarts when it is newly entered, or when the previous cycle
    // had nothing scannable (all channels masked).
    assign scan_start_s = (state_r != ST_SCAN) || !out_valid_r;

    // Output decode: next values of the registered outputs.
    always_comb begin
        out_nxt_s        = out_r;
        out_sel_nxt_s    = out_sel_r;
        out_valid_nxt_s  = 1'b0;
        frame_done_nxt_s = 1'b0;
        sel_err_nxt_s    = 1'b0;
        dwell_nxt_s      = dwell_r;
        case (state_nxt_s)
            ST_IDLE: begin
                dwell_nxt_s = 16'd0;
            end
            ST_MANUAL: begin
                dwell_nxt_s   = 16'd0;
                out_sel_nxt_s = sel;
                if (sel_ok_s) begin
                    out_nxt_s       = chan_at(in, sel);
                    out_valid_nxt_s = 1'b1;
                end else begin
                    out_nxt_s     = '0;
                    sel_err_nxt_s = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!first_found_s) begin
                    dwell_nxt_s = 16'd0;
                end else if (scan_start_s) begin
                    dwell_nxt_s     = 16'd0;
                    out_sel_nxt_s   = first_idx_s;
                    out_nxt_s       = chan_at(in, first_idx_s);
                    out_valid_nxt_s = 1'b1;
                end else if (dwell_r == 16'(DWELL - 1)) begin
                    dwell_nxt_s      = 16'd0;
                    out_sel_nxt_s    = adv_idx_s;
                    out_nxt_s        = chan_at(in, adv_idx_s);
                    out_valid_nxt_s  = 1'b1;
                    frame_done_nxt_s = adv_wrap_s;
                end else begin
                    dwell_nxt_s     = dwell_r + 16'd1;
                    out_nxt_s       = chan_at(in, out_sel_r);
                    out_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                dwell_nxt_s = 16'd0;
            end
        endcase
    end

    // Output and dwell registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r        <= '0;
            out_sel_r    <= '0;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            sel_err_r    <= 1'b0;
            dwell_r      <= 16'd0;
        end else begin
            out_r        <= out_nxt_s;
            out_sel_r    <= out_sel_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            frame_done_r <= frame_done_nxt_s;
            sel_err_r    <= sel_err_nxt_s;
            dwell_r      <= dwell_nxt_s;
        end
    end

    assign out        = out_r;
    assign out_sel    = out_sel_r;
    assign out_valid  = out_valid_r;
    assign frame_done = frame_done_r;
    assign sel_err    = sel_err_r;

endmodule
